bcd_to_binary: RTL and testbench

//  Converts a packed BCD time value (seconds.tenths/hundreths/thousandths) back to
//  a binary millisecond count; the inverse of the stopwatch binary->BCD counter path.

---
 rtl/bcd_to_binary.sv | 143 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Packed BCD (seconds.thousandths) to binary millisecond converter, one digit per clock.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [4*NUM_DIGITS-1:0] bcd_in_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [BIN_W-1:0]        bin_out_o,
    output logic                    err_o
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      shift_q, shift_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [3:0]         nibble;
    logic [BIN_W-1:0]   acc_mac;
    logic               last_digit;

    assign nibble     = shift_q[DW-1 -: 4];
    // acc*10 as two shifts and an add; wraps at BIN_W bits
    assign acc_mac    = (acc_q << 3) + (acc_q << 1) + BIN_W'(nibble);
    assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic err_acc_q, err_acc_d;
    logic bad_digit;

    assign bad_digit = (nibble > 4'd9);
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_d     = err_q;
        err_acc_d = err_acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                // in_ready_q gates acceptance so the first cycle after reset is idle
                if (in_valid_i && in_ready_q) begin
                    shift_d = bcd_in_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StConv;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d     = 1'b0;
                    err_acc_d = 1'b0;
`endif
                end
            end
            StConv: begin
                acc_d   = acc_mac;
                shift_d = shift_q << 4;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
                if (bad_digit) begin
                    err_acc_d = 1'b1;
                end
`endif
                if (last_digit) begin
                    bin_d   = acc_mac;
                    state_d = StDone;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d = err_acc_q | bad_digit;
                    if (err_acc_q || bad_digit) begin
                        bin_d = '0;
                    end
`endif
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            err_acc_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            err_acc_q <= err_acc_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign bin_out_o   = bin_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus random conversions
// checked against a positional-weight arithmetic model.
module tb_bcd_to_binary;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 14;
    localparam int unsigned DW = 4 * N;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] bcd_in_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  bin_out_o;
    logic          err_o;

    int checks = 0;
    int failures = 0;

    bcd_to_binary #(.NUM_DIGITS(N), .BIN_W(W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .bcd_in_i    (bcd_in_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .bin_out_o   (bin_out_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Sum of digit * 10^position, wrapped to W bits; invalid digits zero the result
    // and raise err only when the check feature is built in.
    function automatic logic [W:0] model(input logic [DW-1:0] b);
        int unsigned v = 0;
        int unsigned w = 1;
        logic bad = 1'b0;
        logic [DW-1:0] t = b;
        for (int i = 0; i < int'(N); i++) begin
            v = v + int'(t[3:0]) * w;
            if (t[3:0] > 4'd9) bad = 1'b1;
            w = w * 10;
            t = t >> 4;
        end
`ifdef BCD_DIGIT_CHECK_EN
        if (bad) return {1'b1, {W{1'b0}}};
`else
        bad = 1'b0;
`endif
        return {bad, v[W-1:0]};
    endfunction

    // One full transaction; called #1 after a rising edge with the DUT idle.
    task automatic convert(input logic [DW-1:0] b, input int hold, input logic noise);
        logic [W:0] exp;
        int lat;
        exp = model(b);
        chk("idle_ready", in_ready_o, 1);
        in_valid_i = 1'b1;
        bcd_in_i   = b;
        tick();
        in_valid_i = noise;
        bcd_in_i   = noise ? 16'h7777 : $urandom;
        chk("conv_ready_low", in_ready_o, 0);
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, N);
        chk("bin_out", bin_out_o, exp[W-1:0]);
        chk("err", err_o, exp[W]);
        chk("done_ready_low", in_ready_o, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", out_valid_o, 1);
            chk("hold_bin", bin_out_o, exp[W-1:0]);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        chk("hs_valid_low", out_valid_o, 0);
        chk("hs_idle_ready", in_ready_o, 1);
        chk("bin_held", bin_out_o, exp[W-1:0]);
    endtask

    initial begin
        logic [DW-1:0] r;
        #2;
        chk("rst_ready", in_ready_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_bin", bin_out_o, 0);
        chk("rst_err", err_o, 0);
        #20 rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", in_ready_o, 1);

        convert(16'h1234, 0, 1'b0);
        convert(16'h9999, 0, 1'b0);
        convert(16'h0000, 0, 1'b0);
        convert(16'h0500, 6, 1'b0);
        convert(16'h0321, 1, 1'b1);
        convert(16'h12A4, 0, 1'b0);

        // Reset in the middle of a conversion
        convert(16'h0777, 0, 1'b0);
        tick();
        in_valid_i = 1'b1;
        bcd_in_i   = 16'h1234;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("midrst_bin", bin_out_o, 0);
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_ready", in_ready_o, 0);
        tick();
        tick();
        #2 rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_valid", out_valid_o, 0);
        end
        convert(16'h0042, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            for (int d = 0; d < int'(N); d++) begin
                r[4*d +: 4] = (i % 4 == 3) ? 4'($urandom_range(15, 0))
                                           : 4'($urandom_range(9, 0));
            end
            convert(r, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(1, 0) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
